// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receive path.
//   i2s_rx_state_t : receiver framing state (SYNC, LEFT, RIGHT)
//   WS_LEFT/WS_RIGHT : word-select levels for each channel
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: serial I2S inputs plus the parallel frame outputs.
//   WS, SerialData     : serial side, driven by the I2S source (master)
//   Data, Valid        : completed {left,right} frame and its one-cycle strobe
//   FrameErr           : word-length error strobe, aligned with Valid
// master = I2S source / frame consumer, slave = receiver.
interface i2s_receiver_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 WS;
    logic                 SerialData;
    logic [2*WIDTH-1:0]   Data;
    logic                 Valid;
    logic                 FrameErr;

    modport master (
        output WS,
        output SerialData,
        input  Data,
        input  Valid,
        input  FrameErr
    );

    modport slave (
        input  WS,
        input  SerialData,
        output Data,
        output Valid,
        output FrameErr
    );
endinterface

// File: rtl/i2s_rx_word_shifter.sv
// i2s_rx_word_shifter: MSB-first serial word capture.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bit_i        : serial bit sampled this cycle
//   commit_i     : word boundary; word_o is taken this cycle, then cleared
//   word_o       : current word including bit_i (short words zero-padded)
//   bad_o        : word length incl. bit_i differs from WIDTH
//                  (only present when I2S_RX_FRAME_ERR_EN is defined)
module i2s_rx_word_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_i,
    input  logic             commit_i,
    output logic [WIDTH-1:0] word_o
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    output logic             bad_o
`endif
);
    localparam int unsigned CW = $clog2(WIDTH + 2);

    logic [WIDTH-1:0] shift_q, shift_d, word;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        // Merge the current bit so a commit sees the boundary bit as its LSB.
        word = shift_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(WIDTH - 1 - i)) word[i] = bit_i;
        end

        if (commit_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else begin
            shift_d = word;
            // Saturate at WIDTH+1 so overlong words stay detectable.
            cnt_d   = (cnt_q == CW'(WIDTH + 1)) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o = word;
`ifdef I2S_RX_FRAME_ERR_EN
    assign bad_o  = (cnt_q != CW'(WIDTH - 1));
`endif

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S serial-to-parallel receiver.
//   SCK   : bit clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : i2s_receiver_if slave port (WS, SerialData in; Data, Valid,
//           FrameErr out)
// Optional: define I2S_RX_FRAME_ERR_EN to generate word-length checking;
// otherwise FrameErr is constant 0.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic            SCK,
    input  logic            reset,
    i2s_receiver_if.slave   bus
);
    i2s_rx_state_t      state_q, state_d;
    logic               ws_q;
    logic [WIDTH-1:0]   left_hold_q, left_hold_d;
    logic [2*WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   word;
    logic               ws_edge, ws_rise, ws_fall;

    assign ws_edge = (bus.WS != ws_q);
    assign ws_rise = ws_edge && (bus.WS == WS_RIGHT);
    assign ws_fall = ws_edge && (bus.WS == WS_LEFT);

`ifdef I2S_RX_FRAME_ERR_EN
    logic word_bad;
    logic left_err_q, left_err_d;
    logic ferr_q, ferr_d;
`endif

    i2s_rx_word_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk_i    (SCK),
        .rst_i    (reset),
        .bit_i    (bus.SerialData),
        .commit_i (ws_edge),
        .word_o   (word)
`ifdef I2S_RX_FRAME_ERR_EN
        ,
        .bad_o    (word_bad)
`endif
    );

    always_comb begin
        state_d     = state_q;
        left_hold_d = left_hold_q;
        data_d      = data_q;
        valid_d     = 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
        left_err_d  = left_err_q;
        ferr_d      = 1'b0;
`endif
        case (state_q)
            SYNC: begin
                if (ws_fall) state_d = LEFT;
            end
            // A falling edge here means a missed rising edge: stay and realign.
            LEFT: begin
                if (ws_rise) begin
                    left_hold_d = word;
`ifdef I2S_RX_FRAME_ERR_EN
                    left_err_d  = word_bad;
`endif
                    state_d     = RIGHT;
                end
            end
            RIGHT: begin
                if (ws_fall) begin
                    data_d  = {left_hold_q, word};
                    valid_d = 1'b1;
`ifdef I2S_RX_FRAME_ERR_EN
                    ferr_d  = left_err_q | word_bad;
`endif
                    state_d = LEFT;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge SCK) begin
        if (reset) begin
            state_q     <= SYNC;
            ws_q        <= 1'b0;
            left_hold_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
            left_err_q  <= 1'b0;
            ferr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ws_q        <= bus.WS;
            left_hold_q <= left_hold_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
`ifdef I2S_RX_FRAME_ERR_EN
            left_err_q  <= left_err_d;
            ferr_q      <= ferr_d;
`endif
        end
    end

    assign bus.Data  = data_q;
    assign bus.Valid = valid_q;
`ifdef I2S_RX_FRAME_ERR_EN
    assign bus.FrameErr = ferr_q;
`else
    assign bus.FrameErr = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;
    logic SCK;
    logic reset;

    i2s_receiver_if #(.WIDTH(8)) bus ();

    i2s_receiver #(.WIDTH(8)) dut (
        .SCK   (SCK),
        .reset (reset),
        .bus   (bus)
    );

    initial SCK = 1'b0;
    always #5 SCK = ~SCK;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int cyc    = 0;

    // Count posedges and Valid pulses seen 1 time unit after each posedge.
    always @(posedge SCK) begin
        cyc++;
        #1;
        if (bus.Valid === 1'b1) vcount++;
    end

    typedef struct {
        logic [15:0] l_val;
        int          l_len;
        logic [15:0] r_val;
        int          r_len;
        logic [15:0] exp_data;
        logic        exp_bad;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bit slot; returns 2 time units after the sampling posedge.
    task automatic send_bit(input logic ws, input logic sd);
        @(negedge SCK);
        bus.WS         = ws;
        bus.SerialData = sd;
        @(posedge SCK);
        #2;
    endtask

    // MSB first; the LSB slot carries the next channel's WS level.
    task automatic send_word(input logic [15:0] val, input int len,
                             input logic ws_word, input logic ws_last);
        for (int i = len - 1; i >= 0; i--)
            send_bit((i == 0) ? ws_last : ws_word, val[i]);
    endtask

    task automatic send_frame(input logic [15:0] l, input int ll,
                              input logic [15:0] r, input int rl);
        send_word(l, ll, 1'b0, 1'b1);
        send_word(r, rl, 1'b1, 1'b0);
    endtask

    vec_t vecs[5];
    int   v0;
    int   prev_cyc;
    logic exp_ferr;

    initial begin
        vecs[0] = '{16'h00A5, 8,  16'h003C, 8,  16'hA53C, 1'b0};
        vecs[1] = '{16'h002D, 6,  16'h003F, 6,  16'hB4FC, 1'b1};
        vecs[2] = '{16'h0333, 10, 16'h0001, 10, 16'hCC00, 1'b1};
        vecs[3] = '{16'h0012, 8,  16'h0034, 8,  16'h1234, 1'b0};
        vecs[4] = '{16'h007F, 7,  16'h0001, 8,  16'hFE01, 1'b1};

        reset          = 1'b1;
        bus.WS         = 1'b1;
        bus.SerialData = 1'b0;
        repeat (3) @(posedge SCK);
        #2;
        check("reset_data",  32'(bus.Data),     32'h0);
        check("reset_valid", 32'(bus.Valid),    32'h0);
        check("reset_ferr",  32'(bus.FrameErr), 32'h0);

        // Release mid right word: partial frame must not be reported.
        @(negedge SCK);
        reset = 1'b0;
        v0 = vcount;
        repeat (4) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        check("partial_no_valid", 32'(vcount - v0), 32'h0);

        // Table vectors, back-to-back.
        for (int k = 0; k < 5; k++) begin
            v0 = vcount;
            send_frame(vecs[k].l_val, vecs[k].l_len, vecs[k].r_val, vecs[k].r_len);
`ifdef I2S_RX_FRAME_ERR_EN
            exp_ferr = vecs[k].exp_bad;
`else
            exp_ferr = 1'b0;
`endif
            check($sformatf("vec%0d_valid", k), 32'(bus.Valid),    32'h1);
            check($sformatf("vec%0d_data", k),  32'(bus.Data),     32'(vecs[k].exp_data));
            check($sformatf("vec%0d_ferr", k),  32'(bus.FrameErr), 32'(exp_ferr));
            check($sformatf("vec%0d_pulses", k), 32'(vcount - v0), 32'h1);
        end

        // Ten back-to-back frames: Valid every 16 cycles with matching Data.
        prev_cyc = cyc;
        for (int f = 0; f < 10; f++) begin
            logic [15:0] l, r;
            l  = 16'(8'(f * 16 + 1));
            r  = 16'(8'(f * 16 + 2));
            v0 = vcount;
            send_frame(l, 8, r, 8);
            check($sformatf("b2b%0d_spacing", f), 32'(cyc - prev_cyc), 32'd16);
            check($sformatf("b2b%0d_data", f),    32'(bus.Data), 32'({l[7:0], r[7:0]}));
            check($sformatf("b2b%0d_pulses", f),  32'(vcount - v0), 32'h1);
            prev_cyc = cyc;
        end

        // One-cycle reset in the middle of a left word.
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        @(negedge SCK);
        reset = 1'b1;
        @(posedge SCK);
        #2;
        check("midreset_data",  32'(bus.Data),  32'h0);
        check("midreset_valid", 32'(bus.Valid), 32'h0);
        reset = 1'b0;
        v0 = vcount;
        repeat (4) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        repeat (7) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        check("midreset_no_valid", 32'(vcount - v0), 32'h0);
        check("midreset_hold",     32'(bus.Data),    32'h0);
        send_frame(16'h005A, 8, 16'h00C3, 8);
        check("resync_valid",  32'(bus.Valid),    32'h1);
        check("resync_data",   32'(bus.Data),     32'h5AC3);
        check("resync_ferr",   32'(bus.FrameErr), 32'h0);
        check("resync_pulses", 32'(vcount - v0),  32'h1);

        // Data holds once Valid drops.
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        check("hold_valid", 32'(bus.Valid), 32'h0);
        check("hold_data",  32'(bus.Data),  32'h5AC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Serial-to-parallel I2S receiver; the receive-side counterpart of the team's I2S transmitter. Samples SerialData on rising SCK and tracks WS (low = left, high = right) with the standard one-bit MSB delay. Outputs each completed stereo frame as one {left,right} word with a single-cycle Valid pulse. Sits between an external I2S source (codec/ADC) and the parallel audio datapath.

## Interface
- WIDTH, 8, bits per channel word; the output word is 2*WIDTH bits.
- SCK  input  1  serial bit clock; the only clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- WS  input  1  word select: 0 = left channel, 1 = right channel.
- SerialData  input  1  serial data, MSB first.
- Data  output  2*WIDTH  last complete frame: [2*WIDTH-1:WIDTH] = left, [WIDTH-1:0] = right.
- Valid  output  1  one-cycle pulse when Data updates.
- FrameErr  output  1  one-cycle pulse alongside Valid when either word of the frame had a length other than WIDTH. Tied 0 unless the macro is defined.

## Operation
- Registers:
  - ws_q: WS sampled each posedge; reset 0.
  - Edge at a posedge means WS != ws_q. Rising = 0→1; falling = 1→0.
- Protocol alignment:
  - The bit sampled at an edge posedge is the LSB of the outgoing word.
  - The bit sampled at the next posedge is the MSB of the new word.
- Bit capture: the current SerialData bit is captured on every posedge, including edge posedges.
  - Capture writes shift[WIDTH-1-bit_cnt] when bit_cnt < WIDTH; otherwise the bit is dropped.
  - bit_cnt increments and saturates at WIDTH+1.
- Word commit on an edge posedge:
  - Commit the word including the current bit.
  - Unwritten positions are 0, so short words are MSB-aligned and zero-padded.
  - Then clear shift and set bit_cnt = 0.
- Word length: the length includes the edge bit. A word is bad when bit_cnt+1 != WIDTH at commit.
- State machine (states SYNC, LEFT, RIGHT):
  - SYNC: capture runs, commits are discarded. A falling edge moves to LEFT.
  - LEFT: a rising edge commits the left word into left_hold and moves to RIGHT. A falling edge (impossible without a rising edge) is treated as a resync: stay in LEFT, discard.
  - RIGHT: a falling edge commits the right word, loads Data = {left_hold, word}, pulses Valid, and moves to LEFT.
- The first partial word after reset is never reported. The first Valid comes from the first full left+right pair that follows a WS falling edge.
- Data holds its value between Valid pulses.
- Reset (any cycle, including mid-word) sets:
  - state=SYNC, Data=0, Valid=0, FrameErr=0, left_hold=0, shift=0, bit_cnt=0, ws_q=0.
  - Any partial frame is lost.

## Timing
- All outputs are registered.
- Valid rises at the posedge that samples WS=0 together with the right-channel LSB, and is high for exactly one SCK cycle.
- Latency from that right LSB to Data/Valid: 0 cycles after the capturing edge, i.e. visible in the following cycle.
- With continuous correct framing, Valid pulses every 2*WIDTH SCK cycles.
- Simultaneous reset and edge: reset wins.

## Configuration
- I2S_RX_FRAME_ERR_EN defined:
  - An error flag is tracked for the left word and for the right word.
  - FrameErr = left_err | right_err, asserted in the same cycle as Valid.
  - Data is still delivered.
- Not defined: no length-check logic is generated and FrameErr is constant 0. All other behaviour is identical.

## Structure
- Package i2s_pkg holds:
  - typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t
  - WS_LEFT = 1'b0 and WS_RIGHT = 1'b1 constants.
- Sub-module i2s_rx_word_shifter: MSB-first capture with bit_cnt, saturation, zero padding, and commit/clear. The top level owns edge detection, the FSM and the output registers.

## Test plan
- WIDTH=8, after sync, frame L=0xA5, R=0x3C with correct WS alignment -> Data=0xA53C, Valid high for 1 cycle at the R-LSB posedge, FrameErr=0.
- Reset released with WS high, mid right word -> no Valid for that partial frame. The first Valid carries the first full frame after the WS falling edge.
- Six-bit words L=0b101101, R=0b111111 -> Data=0xB4FC, Valid=1, FrameErr=1 with the macro and 0 without.
- Ten-bit words L=0b1100110011, R=0b0000000001 -> Data=0xCC00 (extra bits dropped), FrameErr=1 with the macro.
- Reset asserted for 1 cycle mid left word -> Data=0 and Valid=0 the next cycle. Valid does not return until after the next falling edge plus a full frame.
- 10 back-to-back frames with an incrementing pattern -> 10 Valid pulses spaced exactly 16 SCK cycles apart, each Data matching the sent pair.
